// File: rtl/mux8_pkg.sv
// Shared definitions for the 8:1 mux controllers.
// Round-robin pick is reused by future mux front-ends.
package mux8_pkg;

  localparam int N_IN  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req at or after start, wrapping mod N_IN.
  // Walks offsets high-to-low so the lowest offset wins.
  function automatic pick_t rr_pick(
    input logic [N_IN-1:0]  req,
    input logic [SEL_W-1:0] start
  );
    pick_t            r;
    logic [SEL_W-1:0] k;
    r = '0;
    for (int n = N_IN - 1; n >= 0; n--) begin
      k = start + SEL_W'(n);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux8_1.sv
// Plain 8:1 single-bit multiplexer.
// Shared datapath in front of which the arbiter sits.
module mux8_1
  import mux8_pkg::*;
(
  input  logic [N_IN-1:0]  i,
  input  logic [SEL_W-1:0] sel,
  output logic             y0
);

  assign y0 = i[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one mux8_1 among eight
// requesters, with a per-grant burst cap and valid/ready.
module mux8_rr_arbiter
  import mux8_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req,
  input  logic [N_IN-1:0]  i,
  input  logic             ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  gnt,
  output logic             y0,
  output logic             y_valid
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CW-1:0]    cnt;

  logic  xfer;
  logic  rel;
  logic  arb;
  pick_t win;

  // Handshake qualification and release decision.
  always_comb begin
    y_valid = (state == GRANT) && req[sel];
    xfer    = y_valid && ready;
    rel     = (state == GRANT) &&
              (!req[sel] || (xfer && cnt == LAST));
    arb     = (state == IDLE) || rel;
    win     = rr_pick(req, ptr + SEL_W'(1));
  end

  // Grant FSM: arbitrate on idle or release, else count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      gnt   <= '0;
      ptr   <= SEL_W'(N_IN - 1);
      cnt   <= '0;
    end else if (arb) begin
      cnt <= '0;
      if (win.found) begin
        state <= GRANT;
        sel   <= win.idx;
        ptr   <= win.idx;
        gnt   <= N_IN'(1) << win.idx;
      end else begin
        state <= IDLE;
        gnt   <= '0;
      end
    end else if (xfer) begin
      cnt <= cnt + CW'(1);
    end
  end

  mux8_1 u_mux (
    .i  (i),
    .sel(sel),
    .y0 (y0)
  );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: vector table,
// directed corner sequences and a randomized model run.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] i;
  logic       ready;

  logic [2:0] sel_a, sel_b;
  logic [7:0] gnt_a, gnt_b;
  logic       y0_a, y0_b;
  logic       yv_a, yv_b;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.MAX_BURST(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .i      (i),
    .ready  (ready),
    .sel    (sel_a),
    .gnt    (gnt_a),
    .y0     (y0_a),
    .y_valid(yv_a)
  );

  mux8_rr_arbiter #(.MAX_BURST(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .i      (i),
    .ready  (ready),
    .sel    (sel_b),
    .gnt    (gnt_b),
    .y0     (y0_b),
    .y_valid(yv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 idle), accepted
  // transfers in this grant, last granted index.
  int m_owner[2];
  int m_last[2];
  int m_cnt[2];
  int m_sel[2];
  int lim[2] = '{4, 1};

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_last[k]  = 7;
      m_cnt[k]   = 0;
      m_sel[k]   = 0;
    end
  endtask

  task automatic mstep(input int k);
    bit v, x, relz;
    v = (m_owner[k] >= 0) && req[m_owner[k]];
    x = v && ready;
    relz = (m_owner[k] < 0) || !req[m_owner[k]] ||
           (x && (m_cnt[k] + 1 == lim[k]));
    if (relz) begin
      m_owner[k] = -1;
      for (int d = 1; d <= 8; d++) begin
        if (m_owner[k] < 0 && req[(m_last[k] + d) % 8])
          m_owner[k] = (m_last[k] + d) % 8;
      end
      m_cnt[k] = 0;
      if (m_owner[k] >= 0) begin
        m_last[k] = m_owner[k];
        m_sel[k]  = m_owner[k];
      end
    end else if (x) begin
      m_cnt[k]++;
    end
  endtask

  task automatic mcheck(input int k);
    int eg, ev;
    eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
    ev = (m_owner[k] >= 0) && req[m_owner[k]];
    if (k == 0) begin
      chk("rnd_gnt_b4", gnt_a, eg);
      chk("rnd_sel_b4", sel_a, m_sel[k]);
      chk("rnd_vld_b4", yv_a, ev);
      chk("rnd_y0_b4", y0_a, i[m_sel[k]]);
    end else begin
      chk("rnd_gnt_b1", gnt_b, eg);
      chk("rnd_sel_b1", sel_b, m_sel[k]);
      chk("rnd_vld_b1", yv_b, ev);
      chk("rnd_y0_b1", y0_b, i[m_sel[k]]);
    end
  endtask

  task automatic drive(input logic [7:0] r,
                       input logic [7:0] d,
                       input logic rd);
    @(negedge clk);
    req   = r;
    i     = d;
    ready = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0);
    mstep(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    #2;
    rst_n = 1'b1;
    mreset();
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] i;
    logic       ready;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       v;
    logic       y;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    i     = '0;
    ready = 1'b0;
    mreset();
    #3;
    chk("rst_sel", sel_a, 0);
    chk("rst_gnt", gnt_a, 0);
    chk("rst_vld", yv_a, 0);
    chk("rst_gnt_b1", gnt_b, 0);
    #4 rst_n = 1'b1;

    // Burst cap 4 between requesters 0 and 2.
    tbl[0] = '{8'h05, 8'h01, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1};
    for (int n = 1; n <= 4; n++)
      tbl[n] = '{8'h05, 8'h01, 1'b1, 3'd0, 8'h01, 1'b1, 1'b1};
    for (int n = 5; n <= 8; n++)
      tbl[n] = '{8'h05, 8'h01, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0};
    tbl[9] = '{8'h05, 8'h01, 1'b1, 3'd0, 8'h01, 1'b1, 1'b1};
    for (int n = 0; n < 10; n++) begin
      drive(tbl[n].req, tbl[n].i, tbl[n].ready);
      chk($sformatf("tbl%0d_sel", n), sel_a, tbl[n].sel);
      chk($sformatf("tbl%0d_gnt", n), gnt_a, tbl[n].gnt);
      chk($sformatf("tbl%0d_vld", n), yv_a, tbl[n].v);
      chk($sformatf("tbl%0d_y0", n), y0_a, tbl[n].y);
      tick();
    end

    // Lone requester 7 is re-granted without a gap.
    do_reset();
    drive(8'h80, 8'hAA, 1'b1);
    tick();
    for (int n = 0; n < 10; n++) begin
      drive(8'h80, 8'hAA, 1'b1);
      chk("solo7_gnt", gnt_a, 8'h80);
      chk("solo7_sel", sel_a, 7);
      chk("solo7_vld", yv_a, 1);
      chk("solo7_y0", y0_a, 1);
      tick();
    end

    // Stalled grantee 3 keeps its full burst budget.
    do_reset();
    drive(8'h18, 8'h00, 1'b0);
    tick();
    for (int n = 0; n < 5; n++) begin
      drive(8'h18, 8'h00, 1'b0);
      chk("stall_gnt", gnt_a, 8'h08);
      chk("stall_sel", sel_a, 3);
      tick();
    end
    for (int n = 0; n < 4; n++) begin
      drive(8'h18, 8'h00, 1'b1);
      chk("stall_xfer_gnt", gnt_a, 8'h08);
      tick();
    end
    drive(8'h18, 8'h00, 1'b1);
    chk("stall_hand_gnt", gnt_a, 8'h10);
    chk("stall_hand_sel", sel_a, 4);
    tick();

    // MAX_BURST=1 rotates every transfer.
    do_reset();
    drive(8'hFF, 8'h00, 1'b1);
    tick();
    for (int n = 0; n < 9; n++) begin
      drive(8'hFF, 8'h00, 1'b1);
      chk("rot_sel", sel_b, n % 8);
      chk("rot_gnt", gnt_b, 1 << (n % 8));
      tick();
    end

    // Grantee 2 drops its request mid-burst.
    do_reset();
    drive(8'h24, 8'h00, 1'b1);
    tick();
    drive(8'h24, 8'h00, 1'b1);
    chk("drop_pre_gnt", gnt_a, 8'h04);
    tick();
    drive(8'h20, 8'h00, 1'b1);
    chk("drop_vld", yv_a, 0);
    tick();
    drive(8'h20, 8'h20, 1'b1);
    chk("drop_gnt", gnt_a, 8'h20);
    chk("drop_sel", sel_a, 5);
    chk("drop_y0", y0_a, 1);
    tick();
    drive(8'h00, 8'h00, 1'b1);
    chk("none_vld", yv_a, 0);
    tick();
    drive(8'h00, 8'h00, 1'b1);
    chk("idle_gnt", gnt_a, 0);
    chk("idle_vld", yv_a, 0);
    chk("idle_sel", sel_a, 5);
    tick();

    // Asynchronous reset in the middle of a burst.
    do_reset();
    drive(8'h02, 8'h00, 1'b1);
    tick();
    drive(8'h02, 8'h00, 1'b1);
    chk("mid_pre_gnt", gnt_a, 8'h02);
    tick();
    @(negedge clk);
    #2;
    req   = 8'h06;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt_a, 0);
    chk("arst_vld", yv_a, 0);
    chk("arst_sel", sel_a, 0);
    #1;
    rst_n = 1'b1;
    mreset();
    tick();
    drive(8'h06, 8'h00, 1'b1);
    chk("arst_first_gnt", gnt_a, 8'h02);
    chk("arst_first_sel", sel_a, 1);
    tick();

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = 8'($urandom & $urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      drive(r, 8'($urandom), $urandom_range(0, 3) != 0);
      mcheck(0);
      mcheck(1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares the `mux8_1` 8:1 datapath between eight requesters. It decides which input the mux presents, and drives `sel` and a one-hot grant vector. It also qualifies the mux output with a valid/ready handshake toward a single downstream consumer. The block sits directly in front of the `mux8_1` instance and caps how many consecutive transfers one requester may hold the path.

## Interface
- `MAX_BURST`, default 4: maximum consecutive accepted transfers per grant; legal range 1..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  per-requester request; `req[k]` held high while requester k has data on `i[k]`.
- `i`  in  8  per-requester data bit, forwarded through the mux.
- `ready`  in  1  downstream accepts `y0` this cycle.
- `sel`  out  3  registered mux select (index of current grantee).
- `gnt`  out  8  registered one-hot grant; all-zero when idle.
- `y0`  out  1  `i[sel]`, combinational through the mux.
- `y_valid`  out  1  `y0` carries valid data; equals `(state==GRANT) && req[sel]`.

## Operation
- States: IDLE, GRANT. Internal registers: `ptr` (3 b, last granted index) and `cnt` (burst count, `$clog2(MAX_BURST+1)` bits).
- Transfer occurs on any cycle where `y_valid && ready`.
- Arbitration searches `req` starting at `(ptr+1) mod 8` and wraps through 7 to 0. The first set bit wins; indices wrap modulo 8.
- IDLE: when `req != 0`, arbitrate. At the edge, load `sel` and `gnt` from the winner, set `ptr` to the winner, clear `cnt`, and go to GRANT. When `req == 0`, stay in IDLE with `gnt = 0`.
- GRANT, release conditions (evaluated at the edge):
  - (a) `req[sel] == 0`
  - (b) a transfer occurs with `cnt == MAX_BURST-1`
- GRANT, no release: on a transfer, `cnt` increments. With no transfer (`ready` low), hold all registers.
- GRANT, release, other requests pending: re-arbitrate in the same edge, load the new grant, clear `cnt`, and stay in GRANT. There is no idle bubble.
- GRANT, release, `req == 0` after masking: go to IDLE and set `gnt = 0`.
- Release under (b) while the same requester is the only one requesting: it is re-granted with `cnt` cleared.
- `sel` holds its last value in IDLE. `gnt` is always exactly zero or one-hot, and `gnt[sel]` is set whenever the state is GRANT.
- With `MAX_BURST = 1`, the grant rotates after every accepted transfer.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE
  - `sel = 3'b000`, `gnt = 8'h00`, `y_valid = 0`
  - `ptr = 3'd7`, so index 0 has highest priority first
  - `cnt = 0`
- Reset asserted mid-burst drops `gnt` and `y_valid` without waiting for a clock edge. The first grant after reset deassertion follows the normal request-to-grant latency.
- Request-to-grant latency: `req` first seen high at edge n produces `gnt`/`sel` valid after edge n; `y_valid` is high in cycle n+1.
- Handover after a burst limit: the new grant is visible in the cycle after the final transfer, with zero dead cycles.
- Handover after a request drop: the grantee's `req` falls in cycle m. `y_valid` is low in cycle m, and the new grant is active in m+1.
- `y0` follows `i[sel]` combinationally. Requesters must hold `i[k]` stable while `y_valid && !ready`.
- `ready` high while `y_valid` is low has no effect.

## Structure
- Shared package `mux8_pkg` holds:
  - `N_IN = 8` and `SEL_W = 3`
  - the state typedef `{IDLE, GRANT}`
  - the round-robin pick function (request vector plus start index returns found flag plus index), shared with future mux controllers
- Sub-module: one existing `mux8_1` instance (`.i(i)`, `.sel(sel)`, `.y0(y0)`). The arbiter FSM and counters live in this module.

## Test plan
- Reset then `req = 8'h05`, `ready = 1`, `MAX_BURST = 4`: `gnt = 8'h01`, `sel = 0` one cycle later; 4 transfers, then `gnt = 8'h04`, `sel = 2` with no bubble; after 4 more, back to `gnt = 8'h01`.
- `req = 8'h80` alone, `i = 8'hAA`, `ready = 1`: `sel = 7`, `y0 = 1`, `y_valid = 1`. After 4 transfers, re-granted to 7 with `cnt` cleared; `gnt` stays `8'h80` continuously.
- Grantee 3 (`req = 8'h08`) with `ready = 0` for 5 cycles: `gnt` and `sel` hold, `cnt` stays 0. Raise `ready`: exactly 4 transfers are counted before release.
- `req = 8'hFF`, `ready = 1`, `MAX_BURST = 1`: `sel` steps 0,1,2,...,7,0 on consecutive cycles, and `gnt` is always one-hot.
- Grantee 2 drops `req` mid-burst while `req[5] = 1`: `y_valid = 0` for one cycle, then `gnt = 8'h20`, `sel = 5`. All `req` dropped: IDLE with `gnt = 0`, `y_valid = 0`.
- Assert `rst_n = 0` mid-burst (between clock edges): `gnt = 0`, `y_valid = 0`, `sel = 0` immediately. After release with `req = 8'h06`: the first grant is index 1.
